// File: rtl/dcache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the
// direct-mapped write-back data cache.
package dcache_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_W    = 32;
    localparam int LINES      = 1 << INDEX_W;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                                     input logic [OFFSET_W-1:0] off);
        return blk[{off, 3'b000} +: DATA_W];
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Eight-line storage for the data cache: data/tag arrays plus valid/dirty bits.
// Valid and dirty clear on RESET; data and tag contents survive reset.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [INDEX_W-1:0]   index,
    output logic [BLOCK_W-1:0]   line_data,
    output logic [TAG_W-1:0]     line_tag,
    output logic                 line_valid,
    output logic                 line_dirty,
    input  logic                 byte_we,
    input  logic [OFFSET_W-1:0]  byte_offset,
    input  logic [DATA_W-1:0]    byte_data,
    input  logic                 fill_we,
    input  logic [BLOCK_W-1:0]   fill_data,
    input  logic [TAG_W-1:0]     fill_tag
);

    logic [BLOCK_W-1:0] data_r [LINES];
    logic [TAG_W-1:0]   tag_r  [LINES];
    logic [LINES-1:0]   valid_r;
    logic [LINES-1:0]   dirty_r;

    // Combinational read port for the addressed line.
    always_comb begin
        line_data  = data_r[index];
        line_tag   = tag_r[index];
        line_valid = valid_r[index];
        line_dirty = dirty_r[index];
    end

    // Data and tag storage: a block fill takes priority over a byte write.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            data_r[index] <= fill_data;
            tag_r[index]  <= fill_tag;
        end else if (byte_we) begin
            data_r[index][{byte_offset, 3'b000} +: DATA_W] <= byte_data;
        end
    end

    // Line status bits with synchronous clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_r <= {LINES{1'b0}};
            dirty_r <= {LINES{1'b0}};
        end else if (fill_we) begin
            valid_r[index] <= 1'b1;
            dirty_r[index] <= 1'b0;
        end else if (byte_we) begin
            dirty_r[index] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller: hit detection, miss FSM
// (writeback / allocate / update) and CPU/memory-side output muxing.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic [DATA_W-1:0]     WRITEDATA,
    output logic [DATA_W-1:0]     READDATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]    MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    state_t               state_r, next_s;
    logic                 started_r;
    logic [BLOCK_W-1:0]   fill_r;
    logic [DATA_W-1:0]    readdata_r;

    logic [TAG_W-1:0]     tag_s;
    logic [INDEX_W-1:0]   index_s;
    logic [OFFSET_W-1:0]  offset_s;
    logic [BLOCK_W-1:0]   line_data_s;
    logic [TAG_W-1:0]     line_tag_s;
    logic                 line_valid_s;
    logic                 line_dirty_s;
    logic                 request_s;
    logic                 is_write_s;
    logic                 is_read_s;
    logic                 hit_s;
    logic                 read_hit_s;
    logic                 byte_we_s;
    logic                 fill_we_s;
    logic                 mem_done_s;
    logic [DATA_W-1:0]    sel_byte_s;

    // Requests seen while RESET is high are dropped; READ+WRITE acts as a write.
    always_comb begin
        tag_s      = addr_tag(ADDRESS);
        index_s    = addr_index(ADDRESS);
        offset_s   = addr_offset(ADDRESS);
        request_s  = (READ | WRITE) & ~RESET;
        is_write_s = WRITE & ~RESET;
        is_read_s  = READ & ~WRITE & ~RESET;
        hit_s      = line_valid_s & (line_tag_s == tag_s);
        read_hit_s = (state_r == IDLE) & is_read_s & hit_s;
        byte_we_s  = (state_r == IDLE) & is_write_s & hit_s;
        fill_we_s  = (state_r == UPDATE) & ~RESET;
        mem_done_s = started_r & ~MEM_BUSYWAIT;
        sel_byte_s = block_byte(line_data_s, offset_s);
    end

    dcache_line_array u_lines (
        .CLK         (CLK),
        .RESET       (RESET),
        .index       (index_s),
        .line_data   (line_data_s),
        .line_tag    (line_tag_s),
        .line_valid  (line_valid_s),
        .line_dirty  (line_dirty_s),
        .byte_we     (byte_we_s),
        .byte_offset (offset_s),
        .byte_data   (WRITEDATA),
        .fill_we     (fill_we_s),
        .fill_data   (fill_r),
        .fill_tag    (tag_s)
    );

    // Miss-handling next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (request_s & ~hit_s) begin
                    next_s = (line_valid_s & line_dirty_s) ? WRITEBACK : ALLOCATE;
                end else begin
                    next_s = IDLE;
                end
            end
            WRITEBACK: begin
                if (mem_done_s) begin
                    next_s = ALLOCATE;
                end else begin
                    next_s = WRITEBACK;
                end
            end
            ALLOCATE: begin
                if (mem_done_s) begin
                    next_s = UPDATE;
                end else begin
                    next_s = ALLOCATE;
                end
            end
            UPDATE:  next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // The memory only raises busy a cycle after seeing the strobe, so its
    // busy flag is ignored for the first cycle of each transfer state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            started_r <= 1'b0;
        end else begin
            started_r <= (state_r == next_s) &
                         ((state_r == WRITEBACK) | (state_r == ALLOCATE));
        end
    end

    // Block captured from memory as ALLOCATE completes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fill_r <= {BLOCK_W{1'b0}};
        end else if ((state_r == ALLOCATE) & mem_done_s) begin
            fill_r <= MEM_READDATA;
        end
    end

    // Last load result, held while no read hit is in progress.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            readdata_r <= {DATA_W{1'b0}};
        end else if (read_hit_s) begin
            readdata_r <= sel_byte_s;
        end
    end

    // CPU-side outputs.
    always_comb begin
        READDATA = read_hit_s ? sel_byte_s : readdata_r;
        BUSYWAIT = (state_r != IDLE) | (request_s & ~hit_s);
    end

    // Memory-side strobes and address/data decoded from state.
    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = {MEM_ADDR_W{1'b0}};
        MEM_WRITEDATA = {BLOCK_W{1'b0}};
        case (state_r)
            WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {line_tag_s, index_s};
                MEM_WRITEDATA = line_data_s;
            end
            ALLOCATE: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {tag_s, index_s};
            end
            IDLE:    MEM_READ = 1'b0;
            UPDATE:  MEM_READ = 1'b0;
            default: MEM_READ = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: a multi-cycle block memory model,
// a byte-level golden memory and a queue of expected load results.
module tb_dcache_controller;

    localparam int MEM_LAT = 3;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'h00;
    logic [7:0]  WRITEDATA = 8'h00;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] exp_q [$];
    logic [7:0] gold [256];

    always #5 CLK = ~CLK;

    dcache_controller dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    function automatic logic [31:0] init_blk(input int b);
        logic [31:0] v;
        v = 32'h0;
        if (b == 9) begin
            v = 32'hDDCCBBAA;
        end else begin
            for (int k = 0; k < 4; k++) v[8*k +: 8] = 8'(((b * 4 + k) * 7) + 3);
        end
        return v;
    endfunction

    // Memory model: busy rises the cycle after it samples a strobe, stays
    // high MEM_LAT cycles, then completes; a held strobe is not re-served.
    logic [31:0] mem_blk [64];
    logic [63:0] mem_written = 64'h0;
    logic        mem_busy_r = 1'b0;
    logic        mem_done_r = 1'b0;
    logic        mem_op_wr  = 1'b0;
    logic [5:0]  mem_addr_r = 6'h0;
    logic [31:0] mem_wdata_r = 32'h0;
    logic [31:0] mem_rdata_r = 32'h0;
    int          mem_cnt = 0;

    assign MEM_BUSYWAIT = mem_busy_r;
    assign MEM_READDATA = mem_rdata_r;

    function automatic logic [31:0] mem_val(input int b);
        return mem_written[b] ? mem_blk[b] : init_blk(b);
    endfunction

    always @(posedge CLK) begin
        if (RESET) begin
            mem_busy_r <= 1'b0;
            mem_done_r <= 1'b0;
            mem_cnt    <= 0;
        end else if (mem_busy_r) begin
            if (mem_cnt == 0) begin
                mem_busy_r <= 1'b0;
                mem_done_r <= 1'b1;
                if (mem_op_wr) begin
                    mem_blk[mem_addr_r]     <= mem_wdata_r;
                    mem_written[mem_addr_r] <= 1'b1;
                end else begin
                    mem_rdata_r <= mem_val(int'(mem_addr_r));
                end
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end else if (MEM_WRITE && !(mem_done_r && mem_op_wr)) begin
            mem_busy_r <= 1'b1; mem_done_r <= 1'b0; mem_op_wr <= 1'b1;
            mem_cnt <= MEM_LAT - 1; mem_addr_r <= MEM_ADDRESS; mem_wdata_r <= MEM_WRITEDATA;
        end else if (MEM_READ && !(mem_done_r && !mem_op_wr)) begin
            mem_busy_r <= 1'b1; mem_done_r <= 1'b0; mem_op_wr <= 1'b0;
            mem_cnt <= MEM_LAT - 1; mem_addr_r <= MEM_ADDRESS;
        end else if (!(mem_op_wr ? MEM_WRITE : MEM_READ)) begin
            mem_done_r <= 1'b0;
        end
    end

    // Strobe monitor: cycle counts plus the last address/data of each kind.
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    int          both_cycles = 0;
    logic [5:0]  last_rd_addr = 6'h0;
    logic [5:0]  last_wr_addr = 6'h0;
    logic [31:0] last_wr_data = 32'h0;

    always @(posedge CLK) begin
        if (MEM_READ) begin
            rd_cycles    <= rd_cycles + 1;
            last_rd_addr <= MEM_ADDRESS;
        end
        if (MEM_WRITE) begin
            wr_cycles    <= wr_cycles + 1;
            last_wr_addr <= MEM_ADDRESS;
            last_wr_data <= MEM_WRITEDATA;
        end
        if (MEM_READ && MEM_WRITE) both_cycles <= both_cycles + 1;
    end

    task automatic sync_gold();
        for (int b = 0; b < 64; b++) begin
            logic [31:0] v;
            v = mem_val(b);
            for (int k = 0; k < 4; k++) gold[b*4 + k] = v[8*k +: 8];
        end
    endtask

    function automatic logic [31:0] gold_blk(input int b);
        return {gold[b*4+3], gold[b*4+2], gold[b*4+1], gold[b*4]};
    endfunction

    // Drives one CPU request, holds it through any stall and returns what was seen.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] d, output int stall,
                          output logic first_busy, output logic [7:0] rdata);
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
        #1;
        first_busy = BUSYWAIT;
        stall = 0;
        while (BUSYWAIT && stall < 100) begin
            @(negedge CLK);
            #1;
            stall++;
        end
        rdata = READDATA;
        @(posedge CLK);
        #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge CLK);
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
        repeat (cycles) @(negedge CLK);
        RESET = 1'b0;
        sync_gold();
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h25;
        @(posedge CLK);
        #1;
        RESET = 1'b0; READ = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (BUSYWAIT !== 1'b0) begin tests_failed++; $display("FAIL reset_busywait got %b want 0", BUSYWAIT); end
        tests_run++;
        if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin
            tests_failed++; $display("FAIL reset_strobes got rd=%b wr=%b want 0/0", MEM_READ, MEM_WRITE);
        end
        tests_run++;
        if (MEM_ADDRESS !== 6'h00 || MEM_WRITEDATA !== 32'h0) begin
            tests_failed++; $display("FAIL reset_mem_bus got %h/%h want 00/00000000", MEM_ADDRESS, MEM_WRITEDATA);
        end
        tests_run++;
        if (READDATA !== 8'h00) begin tests_failed++; $display("FAIL reset_readdata got %h want 00", READDATA); end
        sync_gold();
    endtask

    task automatic test_read_miss();
        int s; logic fb; logic [7:0] r, e; int rd0, wr0;
        rd0 = rd_cycles; wr0 = wr_cycles;
        exp_q.push_back(gold[8'h25]);
        access(1'b1, 1'b0, 8'h25, 8'h00, s, fb, r);
        e = exp_q.pop_front();
        tests_run++;
        if (fb !== 1'b1) begin tests_failed++; $display("FAIL miss_busy_immediate got %b want 1", fb); end
        tests_run++;
        if (s < 3 || s >= 100) begin tests_failed++; $display("FAIL miss_stall got %0d want 3..99", s); end
        tests_run++;
        if (rd_cycles == rd0 || last_rd_addr !== 6'h09) begin
            tests_failed++; $display("FAIL miss_mem_read got n=%0d addr=%h want n>0 addr=09", rd_cycles - rd0, last_rd_addr);
        end
        tests_run++;
        if (wr_cycles != wr0) begin tests_failed++; $display("FAIL miss_no_write got %0d want 0", wr_cycles - wr0); end
        tests_run++;
        if (r !== e || e !== 8'hBB) begin tests_failed++; $display("FAIL miss_readdata got %h want %h (BB)", r, e); end
    endtask

    task automatic test_write_hit();
        int s; logic fb; logic [7:0] r, e;
        access(1'b0, 1'b1, 8'h25, 8'h5A, s, fb, r);
        gold[8'h25] = 8'h5A;
        tests_run++;
        if (fb !== 1'b0 || s != 0) begin tests_failed++; $display("FAIL write_hit_stall got busy=%b stall=%0d want 0/0", fb, s); end
        for (int i = 0; i < 2; i++) begin
            logic [7:0] a;
            a = (i == 0) ? 8'h25 : 8'h24;
            exp_q.push_back(gold[a]);
            access(1'b1, 1'b0, a, 8'h00, s, fb, r);
            e = exp_q.pop_front();
            tests_run++;
            if (r !== e || s != 0) begin tests_failed++; $display("FAIL read_hit_%h got %h stall=%0d want %h stall=0", a, r, s, e); end
        end
    endtask

    task automatic test_dirty_evict();
        int s; logic fb; logic [7:0] r, e; int wr0; logic [31:0] wb_exp;
        wr0 = wr_cycles;
        wb_exp = gold_blk(9);
        exp_q.push_back(gold[8'h45]);
        access(1'b1, 1'b0, 8'h45, 8'h00, s, fb, r);
        e = exp_q.pop_front();
        tests_run++;
        if (wr_cycles == wr0 || last_wr_addr !== 6'h09 || last_wr_data !== wb_exp || wb_exp !== 32'hDDCC5AAA) begin
            tests_failed++;
            $display("FAIL evict_writeback got n=%0d addr=%h data=%h want n>0 addr=09 data=DDCC5AAA",
                     wr_cycles - wr0, last_wr_addr, last_wr_data);
        end
        tests_run++;
        if (last_rd_addr !== 6'h11) begin tests_failed++; $display("FAIL evict_alloc_addr got %h want 11", last_rd_addr); end
        tests_run++;
        if (r !== e) begin tests_failed++; $display("FAIL evict_readdata got %h want %h", r, e); end
    endtask

    task automatic test_read_write_both();
        int s; logic fb; logic [7:0] r, e; int wr0; logic [31:0] wb_exp;
        access(1'b1, 1'b1, 8'h46, 8'h77, s, fb, r);
        gold[8'h46] = 8'h77;
        tests_run++;
        if (s != 0) begin tests_failed++; $display("FAIL rw_both_stall got %0d want 0", s); end
        exp_q.push_back(gold[8'h46]);
        access(1'b1, 1'b0, 8'h46, 8'h00, s, fb, r);
        e = exp_q.pop_front();
        tests_run++;
        if (r !== e || e !== 8'h77) begin tests_failed++; $display("FAIL rw_both_byte got %h want 77", r); end
        wr0 = wr_cycles;
        wb_exp = gold_blk(8'h11);
        exp_q.push_back(gold[8'h26]);
        access(1'b1, 1'b0, 8'h26, 8'h00, s, fb, r);
        e = exp_q.pop_front();
        tests_run++;
        if (wr_cycles == wr0 || last_wr_addr !== 6'h11 || last_wr_data !== wb_exp) begin
            tests_failed++;
            $display("FAIL rw_both_evict got n=%0d addr=%h data=%h want n>0 addr=11 data=%h",
                     wr_cycles - wr0, last_wr_addr, last_wr_data, wb_exp);
        end
        tests_run++;
        if (r !== e) begin tests_failed++; $display("FAIL rw_both_refill got %h want %h", r, e); end
    endtask

    task automatic test_reset_stale();
        int s; logic fb; logic [7:0] r, e;
        do_reset(2);
        exp_q.push_back(gold[8'h26]);
        access(1'b1, 1'b0, 8'h26, 8'h00, s, fb, r);
        e = exp_q.pop_front();
        tests_run++;
        if (fb !== 1'b1 || s == 0) begin tests_failed++; $display("FAIL stale_after_reset got busy=%b stall=%0d want miss", fb, s); end
        tests_run++;
        if (r !== e) begin tests_failed++; $display("FAIL stale_readdata got %h want %h", r, e); end
    endtask

    task automatic test_reset_mid_alloc();
        int s, n; logic fb; logic [7:0] r, e;
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h2A;
        n = 0;
        while (!(MEM_READ && MEM_BUSYWAIT) && n < 20) begin @(negedge CLK); n++; end
        tests_run++;
        if (n >= 20) begin tests_failed++; $display("FAIL alloc_busy_timeout got %0d cycles want <20", n); end
        RESET = 1'b1; READ = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mid_alloc got rd=%b busy=%b want 0/0", MEM_READ, BUSYWAIT);
        end
        RESET = 1'b0;
        sync_gold();
        repeat (2) @(negedge CLK);
        exp_q.push_back(gold[8'h2A]);
        access(1'b1, 1'b0, 8'h2A, 8'h00, s, fb, r);
        e = exp_q.pop_front();
        tests_run++;
        if (fb !== 1'b1 || r !== e) begin tests_failed++; $display("FAIL re_miss_after_reset got busy=%b data=%h want 1/%h", fb, r, e); end
    endtask

    task automatic test_back_to_back();
        int s; logic fb; logic [7:0] r, e, a, d; logic do_rd;
        for (int i = 0; i < 40; i++) begin
            a = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            d = 8'($urandom_range(0, 255));
            do_rd = ($urandom_range(0, 1) == 1);
            if (do_rd) begin
                exp_q.push_back(gold[a]);
                access(1'b1, 1'b0, a, 8'h00, s, fb, r);
                e = exp_q.pop_front();
                tests_run++;
                if (r !== e || s >= 100) begin tests_failed++; $display("FAIL b2b_read_%h got %h want %h stall=%0d", a, r, e, s); end
            end else begin
                access(1'b0, 1'b1, a, d, s, fb, r);
                gold[a] = d;
                tests_run++;
                if (s >= 100) begin tests_failed++; $display("FAIL b2b_write_%h stall timeout %0d", a, s); end
            end
        end
        tests_run++;
        if (both_cycles != 0) begin tests_failed++; $display("FAIL strobes_exclusive got %0d cycles want 0", both_cycles); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_evict();
        test_read_write_both();
        test_reset_stale();
        test_reset_mid_alloc();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
